mipi_dphy_lane_tx: RTL and testbench



---
 rtl/mipi_tx_pkg.sv | 22 ++
 rtl/mipi_tx_timer.sv | 29 ++
 rtl/mipi_dphy_lane_tx.sv | 177 +++++++++++++++++
 tb/tb_mipi_dphy_lane_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the D-PHY high-speed lane transmitter.
package mipi_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLpx,
        StPrepare,
        StHsZero,
        StSync,
        StData,
        StTrail,
        StExit
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line states as {dp, dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/mipi_tx_timer.sv
// Loadable down-counter used to time the LP and HS phases of a burst.
module mipi_tx_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over counting; the counter parks at zero.
    always_ff @(posedge gclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mipi_dphy_lane_tx.sv
// Single-lane D-PHY HS transmit sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// sync -> payload -> trail -> LP-11. All outputs except tx_ready are registered
// and line up with the state register.
module mipi_dphy_lane_tx
    import mipi_tx_pkg::*;
#(
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 2,
    parameter int unsigned T_HS_ZERO    = 4,
    parameter int unsigned T_HS_TRAIL   = 3,
    parameter int unsigned T_HS_EXIT    = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] hs_dout,
    output logic       hs_oe,
    output logic       lp_dp,
    output logic       lp_dn,
    output logic       lp_oe,
    output logic       busy,
    output logic       underrun
);

    tx_state_e        state_q, state_d;
    logic [7:0]       hs_dout_q, hs_dout_d;
    logic [1:0]       lp_q, lp_d;
    logic             hs_oe_q, hs_oe_d;
    logic             lp_oe_q, lp_oe_d;
    logic             busy_q, busy_d;
    logic             underrun_q, underrun_d;
    logic             last_q, last_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    mipi_tx_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .gclk     (gclk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .value    (timer_value),
        .zero     (timer_zero)
    );

    // Ready only while a byte can be taken: SYNC, or DATA before tx_last was seen.
    assign tx_ready = (state_q == StSync) || ((state_q == StData) && !last_q);

    // Next state, payload/trail byte and underrun detection.
    always_comb begin
        state_d    = state_q;
        hs_dout_d  = 8'h00;
        underrun_d = 1'b0;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (tx_valid) state_d = StLpx;
            end
            StLpx: begin
                if (timer_zero) state_d = StPrepare;
            end
            StPrepare: begin
                if (timer_zero) state_d = StHsZero;
            end
            StHsZero: begin
                if (timer_zero) begin
                    state_d   = StSync;
                    hs_dout_d = SYNC_BYTE;
                end
            end
            StSync, StData: begin
                if (tx_ready && tx_valid) begin
                    state_d   = StData;
                    hs_dout_d = tx_data;
                    last_d    = tx_last;
                end else begin
                    // Trail inverts the final bit shown; SYNC's bit 7 stands in when no payload.
                    state_d    = StTrail;
                    hs_dout_d  = {8{~hs_dout_q[7]}};
                    underrun_d = tx_ready;
                    last_d     = 1'b0;
                end
            end
            StTrail: begin
                hs_dout_d = hs_dout_q;
                if (timer_zero) begin
                    state_d   = StExit;
                    hs_dout_d = 8'h00;
                end
            end
            StExit: begin
                if (timer_zero) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Load the phase timer with T-1 whenever a timed state is entered.
    always_comb begin
        timer_load = (state_d != state_q);
        timer_val  = '0;
        unique case (state_d)
            StLpx:     timer_val = CNT_W'(T_LPX - 1);
            StPrepare: timer_val = CNT_W'(T_HS_PREPARE - 1);
            StHsZero:  timer_val = CNT_W'(T_HS_ZERO - 1);
            StTrail:   timer_val = CNT_W'(T_HS_TRAIL - 1);
            StExit:    timer_val = CNT_W'(T_HS_EXIT - 1);
            default:   timer_val = '0;
        endcase
    end

    // Pad controls decoded from the next state so they register alongside it.
    always_comb begin
        lp_d    = LP11;
        lp_oe_d = 1'b1;
        hs_oe_d = 1'b0;
        unique case (state_d)
            StLpx:     lp_d = LP01;
            StPrepare: lp_d = LP00;
            StHsZero, StSync, StData, StTrail: begin
                lp_d    = LP00;
                lp_oe_d = 1'b0;
                hs_oe_d = 1'b1;
            end
            default: lp_d = LP11;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drops straight back to LP-11.
    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q    <= StIdle;
            hs_dout_q  <= 8'h00;
            lp_q       <= LP11;
            hs_oe_q    <= 1'b0;
            lp_oe_q    <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_dout_q  <= hs_dout_d;
            lp_q       <= lp_d;
            hs_oe_q    <= hs_oe_d;
            lp_oe_q    <= lp_oe_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            last_q     <= last_d;
        end
    end

    // Both drivers on at once would fight on the lane; IDLE always has a spent timer.
    always_ff @(posedge gclk) begin
        if (!rst) begin
            assert (!(hs_oe_q && lp_oe_q));
            assert (state_q != StIdle || timer_value == '0);
        end
    end

    assign hs_dout  = hs_dout_q;
    assign hs_oe    = hs_oe_q;
    assign lp_dp    = lp_q[1];
    assign lp_dn    = lp_q[0];
    assign lp_oe    = lp_oe_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_mipi_dphy_lane_tx.sv
// Bench for the D-PHY lane transmitter: each burst is described as (bytes, how
// many get accepted before tx_valid drops) and a per-cycle expectation list is
// built from the burst timing rules, then compared against the DUT each cycle.
module tb_mipi_dphy_lane_tx;

    localparam int unsigned TLpx   = 2;
    localparam int unsigned TPrep  = 2;
    localparam int unsigned TZero  = 4;
    localparam int unsigned TTrail = 3;
    localparam int unsigned TExit  = 3;
    localparam int unsigned SyncAt = TLpx + TPrep + TZero;

    logic       gclk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] hs_dout;
    logic       hs_oe;
    logic       lp_dp;
    logic       lp_dn;
    logic       lp_oe;
    logic       busy;
    logic       underrun;

    always #5 gclk = ~gclk;

    mipi_dphy_lane_tx #(
        .T_LPX        (TLpx),
        .T_HS_PREPARE (TPrep),
        .T_HS_ZERO    (TZero),
        .T_HS_TRAIL   (TTrail),
        .T_HS_EXIT    (TExit),
        .CNT_W        (8)
    ) dut (
        .gclk     (gclk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .hs_dout  (hs_dout),
        .hs_oe    (hs_oe),
        .lp_dp    (lp_dp),
        .lp_dn    (lp_dn),
        .lp_oe    (lp_oe),
        .busy     (busy),
        .underrun (underrun)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic       chk_dout;
        logic       hs_oe;
        logic       lp_oe;
        logic       dp;
        logic       dn;
        logic       busy;
        logic       ready;
        logic       und;
    } exp_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    string       phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s/%s: got %0h want %0h at %0t", phase, tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic hs, input logic dp, input logic dn,
                                input logic [7:0] d, input logic bsy, input logic rdy,
                                input logic und, input logic chk);
        exp_t e;
        e.dout     = d;
        e.chk_dout = chk;
        e.hs_oe    = hs;
        e.lp_oe    = ~hs;
        e.dp       = dp;
        e.dn       = dn;
        e.busy     = bsy;
        e.ready    = rdy;
        e.und      = und;
        return e;
    endfunction

    // Compare the current cycle at the falling edge, then step to just past the next rise.
    task automatic cycle(input exp_t e);
        @(negedge gclk);
        check("hs_oe", 32'(hs_oe), 32'(e.hs_oe));
        check("lp_oe", 32'(lp_oe), 32'(e.lp_oe));
        check("lp_dp", 32'(lp_dp), 32'(e.dp));
        check("lp_dn", 32'(lp_dn), 32'(e.dn));
        check("busy", 32'(busy), 32'(e.busy));
        check("tx_ready", 32'(tx_ready), 32'(e.ready));
        check("underrun", 32'(underrun), 32'(e.und));
        check("oe_excl", 32'(hs_oe & lp_oe), 32'd0);
        if (e.chk_dout) check("hs_dout", 32'(hs_dout), 32'(e.dout));
        @(posedge gclk);
        #1;
    endtask

    // n bytes offered, k accepted (k < n means tx_valid drops after k bytes).
    // chain keeps tx_valid high once the payload is done; abort_at >= 0 pulses rst there.
    task automatic run_burst(input logic [7:0] bytes [8], input int n, input int k,
                             input bit chain, input int abort_at);
        exp_t       q[$];
        logic [7:0] trail;
        int         i;
        // Request cycle, still idle.
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
        cycle(mk(0, 1, 1, 8'h00, 0, 0, 0, 0));
        // Expected burst, one entry per cycle after the request edge.
        for (int c = 0; c < TLpx; c++)   q.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0));
        for (int c = 0; c < TPrep; c++)  q.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0));
        for (int c = 0; c < TZero; c++)  q.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 1));
        q.push_back(mk(1, 0, 0, 8'hB8, 1, 1, 0, 1));
        for (int c = 0; c < k; c++)
            q.push_back(mk(1, 0, 0, bytes[c], 1, !(k == n && c == n - 1), 0, 1));
        trail = (k > 0) ? {8{~bytes[k-1][7]}} : 8'h00;
        for (int c = 0; c < TTrail; c++)
            q.push_back(mk(1, 0, 0, trail, 1, 0, (c == 0) && (k < n), 1));
        for (int c = 0; c < TExit; c++)  q.push_back(mk(0, 1, 1, 8'h00, 1, 0, 0, 0));
        for (int j = 0; j < q.size(); j++) begin
            if (j < SyncAt) begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end else begin
                i = j - SyncAt;
                if (i < k) begin
                    tx_valid = 1'b1;
                    tx_data  = bytes[i];
                    tx_last  = (k == n) && (i == n - 1);
                end else if (i == k && k < n) begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end else begin
                    tx_valid = chain ? 1'b1 : 1'($urandom);
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end
            if (j == abort_at) rst = 1'b1;
            cycle(q[j]);
            if (j == abort_at) begin
                rst      = 1'b0;
                tx_valid = 1'b0;
                cycle(mk(0, 1, 1, 8'h00, 0, 0, 0, 1));
                return;
            end
        end
        if (!chain) begin
            tx_valid = 1'b0;
            cycle(mk(0, 1, 1, 8'h00, 0, 0, 0, 0));
        end
    endtask

    logic [7:0] bb [8];
    int         n;
    int         k;

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (2) @(posedge gclk);
        #1;
        rst   = 1'b0;
        phase = "reset";
        cycle(mk(0, 1, 1, 8'h00, 0, 0, 0, 1));

        phase = "nominal";
        bb = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(bb, 3, 3, 0, -1);

        phase = "last80";
        bb = '{8'h11, 8'h22, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(bb, 3, 3, 0, -1);

        phase = "single80";
        bb = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(bb, 1, 1, 0, -1);

        phase = "drop_data";
        bb = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(bb, 3, 1, 0, -1);

        phase = "drop_sync";
        run_burst(bb, 3, 0, 0, -1);

        phase = "rst_hszero";
        run_burst(bb, 3, 3, 0, int'(TLpx + TPrep + 1));
        phase = "after_rst1";
        run_burst(bb, 3, 3, 0, -1);

        phase = "rst_data";
        bb = '{8'h5A, 8'hC3, 8'h7E, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(bb, 4, 4, 0, int'(SyncAt + 2));
        phase = "after_rst2";
        run_burst(bb, 4, 4, 0, -1);

        phase = "chain";
        run_burst(bb, 2, 2, 1, -1);
        run_burst(bb, 4, 4, 1, -1);
        run_burst(bb, 1, 1, 0, -1);

        phase = "random";
        for (int r = 0; r < 30; r++) begin
            n = int'($urandom_range(1, 8));
            for (int b = 0; b < 8; b++) bb[b] = 8'($urandom);
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : n;
            run_burst(bb, n, k, 1'($urandom), -1);
        end
        tx_valid = 1'b0;
        phase = "final";
        cycle(mk(0, 1, 1, 8'h00, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
